// File: rtl/sdram_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : sdram_init_seq
// Purpose  : SDR SDRAM power-up initialisation sequencer. After reset it
//            waits T_PWRUP cycles with NOP, then issues PRECHARGE-ALL,
//            NUM_AREF AUTO-REFRESH commands and a LOAD MODE REGISTER, and
//            raises init_done. A reinit request seen while idle reruns the
//            sequence from PRECHARGE without the power-up wait.
// Ports    : sdram_clk  - SDRAM clock (only clock)
//            rst_n      - asynchronous active-low reset
//            reinit_req - rerun request, honoured only while initialised
//            cke        - SDRAM clock enable
//            cmd_reg    - {CS_n, RAS_n, CAS_n, WE_n}
//            sdram_addr - A[ADDR_BITS-1:0] (mode word during LMR, A10 else)
//            sdram_ba   - bank address (always zero)
//            init_done  - high while initialised and idle
// Revision : 1.0 - initial release
// ============================================================================
module sdram_init_seq #(
  parameter int         ADDR_BITS = 12,
  parameter int         BA_BITS   = 2,
  parameter int         T_PWRUP   = 13333,
  parameter int         T_RP      = 3,
  parameter int         T_RFC     = 9,
  parameter int         T_MRD     = 2,
  parameter int         NUM_AREF  = 2,
  parameter logic [2:0] MR_BL     = 3'b010,
  parameter logic       MR_BT     = 1'b0,
  parameter logic [2:0] MR_CL     = 3'b011,
  parameter logic       MR_WB     = 1'b0
) (
  input  logic                 sdram_clk,
  input  logic                 rst_n,
  input  logic                 reinit_req,
  output logic                 cke,
  output logic [3:0]           cmd_reg,
  output logic [ADDR_BITS-1:0] sdram_addr,
  output logic [BA_BITS-1:0]   sdram_ba,
  output logic                 init_done
);

  localparam int C_MAX_A  = (T_PWRUP > T_RP) ? T_PWRUP : T_RP;
  localparam int C_MAX_B  = (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int C_MAX_T  = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
  localparam int C_CNT_W  = $clog2(C_MAX_T) + 1;
  localparam int C_AREF_W = $clog2(NUM_AREF + 1);

  // Power-up counts up from reset; post-command waits count down from T-1,
  // so a wait of 1 cycle moves straight on to the next command.
  localparam logic [C_CNT_W-1:0]  C_PWRUP_END = C_CNT_W'(T_PWRUP);
  localparam logic [C_CNT_W-1:0]  C_RP_LOAD   = C_CNT_W'(T_RP - 1);
  localparam logic [C_CNT_W-1:0]  C_RFC_LOAD  = C_CNT_W'(T_RFC - 1);
  localparam logic [C_CNT_W-1:0]  C_MRD_LOAD  = C_CNT_W'(T_MRD - 1);
  localparam logic [C_AREF_W-1:0] C_NUM_AREF  = C_AREF_W'(NUM_AREF);

  localparam logic [3:0] C_CMD_NOP  = 4'b0111;
  localparam logic [3:0] C_CMD_PRE  = 4'b0010;
  localparam logic [3:0] C_CMD_AREF = 4'b0001;
  localparam logic [3:0] C_CMD_LMR  = 4'b0000;

  // A10 high selects all banks for PRECHARGE; harmless on NOP cycles.
  localparam logic [ADDR_BITS-1:0] C_ADDR_PALL = ADDR_BITS'(1024);
  localparam logic [9:0]           C_MR_WORD   = {MR_WB, 2'b00, MR_CL, MR_BT, MR_BL};
  localparam logic [ADDR_BITS-1:0] C_ADDR_MR   = ADDR_BITS'(C_MR_WORD);

  typedef enum logic [2:0] {
    S_PWRUP    = 3'd0,
    S_PRE      = 3'd1,
    S_WAIT_RP  = 3'd2,
    S_AREF     = 3'd3,
    S_WAIT_RFC = 3'd4,
    S_LMR      = 3'd5,
    S_WAIT_MRD = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t                 state_q, state_d;
  logic [C_CNT_W-1:0]     cnt_q, cnt_d;
  logic [C_AREF_W-1:0]    aref_q, aref_d;
  logic                   cke_q, cke_d;
  logic [3:0]             cmd_q, cmd_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [BA_BITS-1:0]     ba_q;
  logic                   done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    aref_d  = aref_q;

    unique case (state_q)
      S_PWRUP: begin
        if (cnt_q == C_PWRUP_END) begin
          state_d = S_PRE;
          cnt_d   = C_RP_LOAD;
          aref_d  = '0;
        end else begin
          cnt_d = cnt_q + C_CNT_W'(1);
        end
      end
      S_PRE, S_WAIT_RP: begin
        if (cnt_q == '0) begin
          state_d = S_AREF;
          cnt_d   = C_RFC_LOAD;
          aref_d  = aref_q + C_AREF_W'(1);
        end else begin
          state_d = S_WAIT_RP;
          cnt_d   = cnt_q - C_CNT_W'(1);
        end
      end
      S_AREF, S_WAIT_RFC: begin
        if (cnt_q != '0) begin
          state_d = S_WAIT_RFC;
          cnt_d   = cnt_q - C_CNT_W'(1);
        end else if (aref_q == C_NUM_AREF) begin
          state_d = S_LMR;
          cnt_d   = C_MRD_LOAD;
        end else begin
          state_d = S_AREF;
          cnt_d   = C_RFC_LOAD;
          aref_d  = aref_q + C_AREF_W'(1);
        end
      end
      S_LMR, S_WAIT_MRD: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT_MRD;
          cnt_d   = cnt_q - C_CNT_W'(1);
        end
      end
      S_DONE: begin
        if (reinit_req) begin
          state_d = S_PRE;
          cnt_d   = C_RP_LOAD;
          aref_d  = '0;
        end
      end
      default: begin
        state_d = S_PWRUP;
        cnt_d   = '0;
        aref_d  = '0;
      end
    endcase
  end

  // Outputs are registered copies of the decode of the next state, so the
  // command appears on the same cycle the FSM enters its state.
  always_comb begin
    cmd_d  = C_CMD_NOP;
    addr_d = C_ADDR_PALL;
    done_d = (state_d == S_DONE);
    // cke rises one cycle after reset release and then never drops.
    cke_d  = cke_q | (state_q != S_PWRUP) | (cnt_q != '0);
    unique case (state_d)
      S_PRE:   cmd_d = C_CMD_PRE;
      S_AREF:  cmd_d = C_CMD_AREF;
      S_LMR: begin
        cmd_d  = C_CMD_LMR;
        addr_d = C_ADDR_MR;
      end
      default: cmd_d = C_CMD_NOP;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PWRUP;
      cnt_q   <= '0;
      aref_q  <= '0;
      cke_q   <= 1'b0;
      cmd_q   <= C_CMD_NOP;
      addr_q  <= C_ADDR_PALL;
      ba_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      aref_q  <= aref_d;
      cke_q   <= cke_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ba_q    <= '0;
      done_q  <= done_d;
    end
  end

  assign cke        = cke_q;
  assign cmd_reg    = cmd_q;
  assign sdram_addr = addr_q;
  assign sdram_ba   = ba_q;
  assign init_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_init_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sdram_init_seq
// Purpose  : Self-checking bench for sdram_init_seq. Three instances run in
//            lock-step: short timing, short timing with four refreshes and
//            a different mode word, and the default parameters. Expected
//            outputs are computed from the command timeline arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_init_seq;

  localparam int NDUT = 3;

  logic sdram_clk  = 1'b0;
  logic rst_n      = 1'b0;
  logic reinit_req = 1'b0;

  logic [NDUT-1:0]       cke_w;
  logic [NDUT-1:0]       done_w;
  logic [NDUT-1:0][3:0]  cmd_w;
  logic [NDUT-1:0][11:0] addr_w;
  logic [NDUT-1:0][1:0]  ba_w;

  always #5 sdram_clk = ~sdram_clk;

  sdram_init_seq #(
    .ADDR_BITS(12), .BA_BITS(2), .T_PWRUP(20), .T_RP(3), .T_RFC(9),
    .T_MRD(2), .NUM_AREF(2), .MR_BL(3'b010), .MR_BT(1'b0),
    .MR_CL(3'b011), .MR_WB(1'b0)
  ) u_dut0 (
    .sdram_clk(sdram_clk), .rst_n(rst_n), .reinit_req(reinit_req),
    .cke(cke_w[0]), .cmd_reg(cmd_w[0]), .sdram_addr(addr_w[0]),
    .sdram_ba(ba_w[0]), .init_done(done_w[0])
  );

  sdram_init_seq #(
    .ADDR_BITS(12), .BA_BITS(2), .T_PWRUP(20), .T_RP(3), .T_RFC(9),
    .T_MRD(1), .NUM_AREF(4), .MR_BL(3'b011), .MR_BT(1'b0),
    .MR_CL(3'b010), .MR_WB(1'b0)
  ) u_dut1 (
    .sdram_clk(sdram_clk), .rst_n(rst_n), .reinit_req(reinit_req),
    .cke(cke_w[1]), .cmd_reg(cmd_w[1]), .sdram_addr(addr_w[1]),
    .sdram_ba(ba_w[1]), .init_done(done_w[1])
  );

  sdram_init_seq u_dut2 (
    .sdram_clk(sdram_clk), .rst_n(rst_n), .reinit_req(reinit_req),
    .cke(cke_w[2]), .cmd_reg(cmd_w[2]), .sdram_addr(addr_w[2]),
    .sdram_ba(ba_w[2]), .init_done(done_w[2])
  );

  // Reference model parameters, one entry per instance.
  int tpw   [NDUT] = '{20, 20, 13333};
  int trp   [NDUT] = '{3, 3, 3};
  int trfc  [NDUT] = '{9, 9, 9};
  int tmrd  [NDUT] = '{2, 1, 2};
  int naref [NDUT] = '{2, 4, 2};
  int mr    [NDUT];

  int pstart [NDUT];   // cycle at which the latest PRE is expected
  int n;               // cycles since reset release (0 = first edge)
  bit in_rst;
  int rq_pct;
  int n_vec = 0;
  int n_err = 0;

  function automatic int mr_code(input int bl, input int bt, input int cl, input int wb);
    return bl + bt * 8 + cl * 16 + wb * 512;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_done(input int k, input int cyc);
    int l;
    l = trp[k] + naref[k] * trfc[k];
    return (cyc >= tpw[k]) && (cyc - pstart[k] >= l + tmrd[k]);
  endfunction

  task automatic check_all();
    for (int k = 0; k < NDUT; k++) begin
      int e_cke, e_cmd, e_addr, e_done, d, l;
      e_cke  = 0;
      e_cmd  = 'h7;
      e_addr = 'h400;
      e_done = 0;
      if (!in_rst) begin
        if (n < tpw[k]) begin
          e_cke = (n >= 1) ? 1 : 0;
        end else begin
          e_cke = 1;
          d = n - pstart[k];
          l = trp[k] + naref[k] * trfc[k];
          if (d == 0)
            e_cmd = 'h2;
          else if (d >= trp[k] && d < l && ((d - trp[k]) % trfc[k]) == 0)
            e_cmd = 'h1;
          else if (d == l) begin
            e_cmd  = 'h0;
            e_addr = mr[k];
          end
          e_done = exp_done(k, n) ? 1 : 0;
        end
      end
      check_eq($sformatf("d%0d.cke@%0d", k, n),  32'(cke_w[k]),  32'(e_cke));
      check_eq($sformatf("d%0d.cmd@%0d", k, n),  32'(cmd_w[k]),  32'(e_cmd));
      check_eq($sformatf("d%0d.addr@%0d", k, n), 32'(addr_w[k]), 32'(e_addr));
      check_eq($sformatf("d%0d.ba@%0d", k, n),   32'(ba_w[k]),   32'(0));
      check_eq($sformatf("d%0d.done@%0d", k, n), 32'(done_w[k]), 32'(e_done));
    end
  endtask

  // mode 0: no requests; 1: directed (held 25..30, pulse at 60); 2: random
  task automatic run_cycles(input int cnt, input int mode);
    for (int i = 0; i < cnt; i++) begin
      bit rq;
      @(posedge sdram_clk);
      #1;
      n++;
      check_all();
      case (mode)
        1:       rq = ((n >= 25 && n <= 30) || n == 60);
        2:       rq = ($urandom_range(0, 99) < rq_pct);
        default: rq = 1'b0;
      endcase
      reinit_req = rq;
      for (int k = 0; k < NDUT; k++)
        if (rq && exp_done(k, n)) pstart[k] = n + 1;
    end
  endtask

  task automatic do_reset(input int hold);
    rst_n      = 1'b0;
    reinit_req = 1'b0;
    in_rst     = 1'b1;
    #1;
    check_all();
    for (int i = 0; i < hold; i++) begin
      @(posedge sdram_clk);
      #1;
      check_all();
    end
    rst_n  = 1'b1;
    in_rst = 1'b0;
    n      = -1;
    for (int k = 0; k < NDUT; k++) pstart[k] = tpw[k];
  endtask

  initial begin
    mr[0] = mr_code(2, 0, 3, 0);
    mr[1] = mr_code(3, 0, 2, 0);
    mr[2] = mr_code(2, 0, 3, 0);
    n      = -1;
    in_rst = 1'b1;
    rq_pct = 0;

    repeat (2) @(posedge sdram_clk);
    #1;
    do_reset(2);
    run_cycles(90, 1);

    // Reset mid-sequence at cycle 35, held for 5 cycles.
    do_reset(1);
    run_cycles(36, 0);
    do_reset(5);
    run_cycles(60, 0);

    for (int it = 0; it < 25; it++) begin
      rq_pct = $urandom_range(0, 3) * 20;
      run_cycles($urandom_range(20, 160), 2);
      do_reset($urandom_range(0, 4));
    end

    // Long run so the default-parameter instance completes its sequence.
    run_cycles(13400, 0);
    rq_pct = 30;
    run_cycles(120, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
